// File: rtl/ui_input_conditioner_bank.sv
// Multi-channel UI input conditioner: synchronise, normalise polarity, debounce, emit press/release pulses.
// Optional hold/auto-repeat pulses are built when UI_HOLD_REPEAT_EN is defined.
module ui_input_conditioner_bank #(
  parameter int unsigned              NUM_CHANNELS    = 10,
  parameter int unsigned              SYNC_STAGES     = 2,
  parameter int unsigned              DEBOUNCE_CYCLES = 500000,
  parameter logic [NUM_CHANNELS-1:0]  ACTIVE_LOW_MASK = {NUM_CHANNELS{1'b1}}
`ifdef UI_HOLD_REPEAT_EN
  ,
  parameter int unsigned              HOLD_CYCLES     = 50000000,
  parameter int unsigned              REPEAT_CYCLES   = 10000000
`endif
) (
  input  logic                    clock_50Mhz,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] raw_in,
  output logic [NUM_CHANNELS-1:0] level_out,
  output logic [NUM_CHANNELS-1:0] press_pulse,
  output logic [NUM_CHANNELS-1:0] release_pulse,
  output logic                    any_pressed
`ifdef UI_HOLD_REPEAT_EN
  ,
  output logic [NUM_CHANNELS-1:0] hold_pulse
`endif
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef UI_HOLD_REPEAT_EN
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + REPEAT_CYCLES + 1);
`endif

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PENDING,
    PRESSED,
    RELEASE_PENDING
  } state_t;

  logic [SYNC_STAGES-1:0][NUM_CHANNELS-1:0] r_sync;
  logic [NUM_CHANNELS-1:0]                  w_s;
  logic                                     r_any;

  // Reset preloads the inactive pin level so no phantom press follows reset release.
  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      r_sync <= {SYNC_STAGES{ACTIVE_LOW_MASK}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1] ^ ACTIVE_LOW_MASK;

  always_ff @(posedge clock_50Mhz) begin
    if (reset) r_any <= 1'b0;
    else       r_any <= |level_out;
  end

  assign any_pressed = r_any;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_level, w_level_nxt;
    logic             r_press, w_press_nxt;
    logic             r_release, w_release_nxt;

    always_ff @(posedge clock_50Mhz) begin
      if (reset) begin
        r_state   <= RELEASED;
        r_cnt     <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_cnt     <= w_cnt_nxt;
        r_level   <= w_level_nxt;
        r_press   <= w_press_nxt;
        r_release <= w_release_nxt;
      end
    end

    // Any mismatch drops back to the settled state; the counter restarts on the next mismatch.
    always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_level_nxt   = r_level;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      case (r_state)
        RELEASED: begin
          if (w_s[g]) begin
            w_state_nxt = PRESS_PENDING;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        PRESS_PENDING: begin
          if (!w_s[g]) begin
            w_state_nxt = RELEASED;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            w_state_nxt = PRESSED;
            w_cnt_nxt   = '0;
            w_level_nxt = 1'b1;
            w_press_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!w_s[g]) begin
            w_state_nxt = RELEASE_PENDING;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        RELEASE_PENDING: begin
          if (w_s[g]) begin
            w_state_nxt = PRESSED;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            w_state_nxt   = RELEASED;
            w_cnt_nxt     = '0;
            w_level_nxt   = 1'b0;
            w_release_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = RELEASED;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    assign level_out[g]     = r_level;
    assign press_pulse[g]   = r_press;
    assign release_pulse[g] = r_release;

`ifdef UI_HOLD_REPEAT_EN
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_hold;

    // Hold time keeps accumulating through a tentative release; only an accepted release clears it.
    always_ff @(posedge clock_50Mhz) begin
      if (reset) begin
        r_hold_cnt <= '0;
        r_hold     <= 1'b0;
      end else begin
        r_hold <= 1'b0;
        if (w_state_nxt == RELEASED) begin
          r_hold_cnt <= '0;
        end else if (r_state == PRESSED || r_state == RELEASE_PENDING) begin
          if (r_hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
            r_hold     <= 1'b1;
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end else if (REPEAT_CYCLES != 0 &&
                       r_hold_cnt == HOLD_W'(HOLD_CYCLES + REPEAT_CYCLES - 1)) begin
            r_hold     <= 1'b1;
            r_hold_cnt <= HOLD_W'(HOLD_CYCLES);
          end else if (REPEAT_CYCLES != 0 || r_hold_cnt != HOLD_W'(HOLD_CYCLES)) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end
      end
    end

    assign hold_pulse[g] = r_hold;
`endif
  end

endmodule

// File: tb/tb_ui_input_conditioner_bank.sv
// Scoreboard bench for ui_input_conditioner_bank: per-cycle expectations queued at stimulus time.
module tb_ui_input_conditioner_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] raw_in;
  logic [3:0] level_out;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;
  logic       any_pressed;
`ifdef UI_HOLD_REPEAT_EN
  logic [3:0] hold_pulse;
`endif

  always #5 clk = ~clk;

`ifdef UI_HOLD_REPEAT_EN
  ui_input_conditioner_bank #(
    .NUM_CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW_MASK(4'b0011),
    .HOLD_CYCLES(10), .REPEAT_CYCLES(5)
  ) dut (
    .clock_50Mhz(clk), .reset(reset), .raw_in(raw_in), .level_out(level_out),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .any_pressed(any_pressed),
    .hold_pulse(hold_pulse)
  );
`else
  ui_input_conditioner_bank #(
    .NUM_CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW_MASK(4'b0011)
  ) dut (
    .clock_50Mhz(clk), .reset(reset), .raw_in(raw_in), .level_out(level_out),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .any_pressed(any_pressed)
  );
`endif

  typedef struct {
    logic [3:0] lvl;
    logic [3:0] press;
    logic [3:0] rel;
    logic       any;
    logic [3:0] hold;
  } exp_t;

  exp_t       q[$];
  logic [3:0] exp_lvl = 4'b0000;
  int         checks  = 0;
  int         errors  = 0;
  int         cyc     = 0;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s @cycle %0d: observed %b expected %b", tag, cyc, got, want);
    end
  endtask

  // Queue n cycles of expectations; channels in mask settle to 'to' on cycle 'at' (0 = no change).
  task automatic plan(input int n, input int at, input logic [3:0] mask, input logic [3:0] to);
    for (int k = 1; k <= n; k++) begin
      exp_t       e;
      logic [3:0] nl;
      nl      = (k == at) ? ((exp_lvl & ~mask) | (to & mask)) : exp_lvl;
      e.press = nl & ~exp_lvl;
      e.rel   = exp_lvl & ~nl;
      e.any   = |exp_lvl;
      e.lvl   = nl;
      e.hold  = 4'b0000;
      exp_lvl = nl;
      q.push_back(e);
    end
  endtask

  // Advance one edge per queued entry and compare outputs 1 time unit after the edge.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL scoreboard_empty @cycle %0d: observed 0 entries expected 1", cyc);
      end else begin
        e = q.pop_front();
        chk("level_out", level_out, e.lvl);
        chk("press_pulse", press_pulse, e.press);
        chk("release_pulse", release_pulse, e.rel);
        chk("any_pressed", {3'b000, any_pressed}, {3'b000, e.any});
`ifdef UI_HOLD_REPEAT_EN
        chk("hold_pulse", hold_pulse, e.hold);
`endif
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    raw_in = 4'b0011;

    // Reset with every pin at its inactive level, then 20 quiet cycles.
    plan(3, 0, 4'b0000, 4'b0000);
    run(3);
    reset = 1'b0;
    plan(20, 0, 4'b0000, 4'b0000);
    run(20);

    // Channel 0 (active-low) clean press and release.
    raw_in[0] = 1'b0;
    plan(10, 6, 4'b0001, 4'b0001);
    run(10);
    raw_in[0] = 1'b1;
    plan(10, 6, 4'b0001, 4'b0000);
    run(10);

    // Channel 2 (active-high) press, then bouncing release.
    raw_in[2] = 1'b1;
    plan(10, 6, 4'b0100, 4'b0100);
    run(10);
    for (int b = 0; b < 4; b++) begin
      raw_in[2] = b[0];
      plan(2, 0, 4'b0000, 4'b0000);
      run(2);
    end
    raw_in[2] = 1'b0;
    plan(10, 6, 4'b0100, 4'b0000);
    run(10);

    // Channels 1 and 3 pressed together, then released together.
    raw_in = 4'b1001;
    plan(10, 6, 4'b1010, 4'b1010);
    run(10);
    raw_in = 4'b0011;
    plan(10, 6, 4'b1010, 4'b0000);
    run(10);

    // Reset while channel 0 is pressed: level drops silently, then re-asserts.
    raw_in[0] = 1'b0;
    plan(8, 6, 4'b0001, 4'b0001);
    run(8);
    reset   = 1'b1;
    exp_lvl = 4'b0000;
    plan(1, 0, 4'b0000, 4'b0000);
    run(1);
    reset = 1'b0;
    plan(10, 6, 4'b0001, 4'b0001);
    run(10);
    raw_in[0] = 1'b1;
    plan(10, 6, 4'b0001, 4'b0000);
    run(10);

`ifdef UI_HOLD_REPEAT_EN
    // Long press on channel 0: press at k=6, holds at press+10/+15/+20/+25/+30, release raw at press+26.
    raw_in[0] = 1'b0;
    plan(32, 6, 4'b0001, 4'b0001);
    q[15].hold = 4'b0001;
    q[20].hold = 4'b0001;
    q[25].hold = 4'b0001;
    q[30].hold = 4'b0001;
    run(32);
    raw_in[0] = 1'b1;
    plan(20, 6, 4'b0001, 4'b0000);
    q[3].hold = 4'b0001;
    run(20);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
